// File: rtl/fdiv_seq.sv
// Sequential 16-bit float divider (1/8/7 format), restoring mantissa division,
// one quotient bit per clock. Define FDIV_ROUND_EN for an extra guard bit and round-half-up.
module fdiv_seq #(
    parameter int BIAS = 127
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] r,
    output logic        divz
);

`ifdef FDIV_ROUND_EN
    localparam int NQ = 10;
`else
    localparam int NQ = 9;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]    state;
    logic          sgn;
    logic [7:0]    ea, eb, mb;
    logic [9:0]    rem;
    logic [NQ-1:0] q;
    logic [3:0]    cnt;
    logic          zdiv, zdvd;

    // remainder stays below 2*mb, so the shifted value always fits in 10 bits
    logic          rem_ge;
    logic [9:0]    rem_sub;

    always_comb begin
        rem_ge  = rem >= {2'b00, mb};
        rem_sub = rem - {2'b00, mb};
    end

    logic signed [9:0] e_base, e_n;
    logic [6:0]        frac;
    logic [15:0]       r_norm, r_fin;
`ifdef FDIV_ROUND_EN
    logic [6:0]        frac_t;
    logic              guard;
    logic [7:0]        frac_rnd;
`endif

    always_comb begin
        e_base = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(BIAS[9:0]);
`ifdef FDIV_ROUND_EN
        frac_t   = q[NQ-1] ? q[8:2] : q[7:1];
        guard    = q[NQ-1] ? q[1]   : q[0];
        frac_rnd = {1'b0, frac_t} + {7'd0, guard};
        e_n      = q[NQ-1] ? e_base : e_base - 10'sd1;
        // a carry out of the fraction bumps the exponent; overflow is judged afterwards
        if (frac_rnd[7]) begin
            frac = 7'd0;
            e_n  = e_n + 10'sd1;
        end else begin
            frac = frac_rnd[6:0];
        end
`else
        frac = q[NQ-1] ? q[7:1] : q[6:0];
        e_n  = q[NQ-1] ? e_base : e_base - 10'sd1;
`endif
        if (e_n <= 10'sd0)
            r_norm = 16'h0000;
        else if (e_n >= 10'sd255)
            r_norm = {sgn, 8'hff, 7'h7f};
        else
            r_norm = {sgn, e_n[7:0], frac};

        if (zdiv)
            r_fin = {sgn, 8'hff, 7'h7f};
        else if (zdvd)
            r_fin = 16'h0000;
        else
            r_fin = r_norm;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            r     <= 16'h0000;
            divz  <= 1'b0;
            sgn   <= 1'b0;
            ea    <= 8'd0;
            eb    <= 8'd0;
            mb    <= 8'd0;
            rem   <= 10'd0;
            q     <= '0;
            cnt   <= 4'd0;
            zdiv  <= 1'b0;
            zdvd  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sgn   <= a[15] ^ b[15];
                        ea    <= a[14:7];
                        eb    <= b[14:7];
                        mb    <= {1'b1, b[6:0]};
                        rem   <= {3'b001, a[6:0]};
                        q     <= '0;
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                        // divide-by-zero wins over a zero dividend (0/0 flags divz)
                        zdiv  <= (b == 16'h0000);
                        zdvd  <= (a == 16'h0000);
                        state <= (b == 16'h0000 || a == 16'h0000) ? S_FIN : S_DIV;
                    end
                end
                S_DIV: begin
                    q   <= {q[NQ-2:0], rem_ge};
                    rem <= rem_ge ? {rem_sub[8:0], 1'b0} : {rem[8:0], 1'b0};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(NQ - 1))
                        state <= S_FIN;
                end
                S_FIN: begin
                    r     <= r_fin;
                    divz  <= zdiv;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed-vector bench for fdiv_seq: table of divides plus handshake and reset sequences.
module tb_fdiv_seq;

`ifdef FDIV_ROUND_EN
    localparam int LAT = 11;
    localparam logic [15:0] THIRD = 16'h3EAB;
    localparam logic [15:0] NTHIRD = 16'hBEAB;
`else
    localparam int LAT = 10;
    localparam logic [15:0] THIRD = 16'h3EAA;
    localparam logic [15:0] NTHIRD = 16'hBEAA;
`endif

    logic        clk, reset, start;
    logic [15:0] a, b;
    logic        busy, done, divz;
    logic [15:0] r;

    int errors = 0;
    int checks = 0;

    fdiv_seq #(.BIAS(127)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .r(r), .divz(divz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t v[12];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Issue one divide and wait (bounded) for done; lat=-1 on timeout.
    task automatic run(input logic [15:0] ta, input logic [15:0] tb_, input bit nowait,
                       output logic [15:0] rr, output logic dz, output int lat, output bit busy_ok);
        if (!nowait) @(negedge clk);
        a = ta; b = tb_; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; busy_ok = 1'b1; rr = 16'hxxxx; dz = 1'bx;
        if (!busy) busy_ok = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i; rr = r; dz = divz;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    logic [15:0] rr;
    logic        dz;
    int          lat;
    bit          bok;
    bit          seen;

    initial begin
        v[0]  = '{16'h40C0, 16'h4000, 16'h4040, 1'b0, LAT};
        v[1]  = '{16'h3F80, 16'h4040, THIRD,    1'b0, LAT};
        v[2]  = '{16'hC0C0, 16'h4000, 16'hC040, 1'b0, LAT};
        v[3]  = '{16'h3F80, 16'h0000, 16'h7FFF, 1'b1, 1};
        v[4]  = '{16'h0000, 16'h4040, 16'h0000, 1'b0, 1};
        v[5]  = '{16'h7F00, 16'h0080, 16'h7FFF, 1'b0, LAT};
        v[6]  = '{16'h0080, 16'h7F00, 16'h0000, 1'b0, LAT};
        v[7]  = '{16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1};
        v[8]  = '{16'hBF80, 16'h0000, 16'hFFFF, 1'b1, 1};
        v[9]  = '{16'hFF00, 16'h0080, 16'hFFFF, 1'b0, LAT};
        v[10] = '{16'h3F80, 16'h3F80, 16'h3F80, 1'b0, LAT};
        v[11] = '{16'h3F80, 16'hC040, NTHIRD,   1'b0, LAT};

        reset = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_r", {16'd0, r}, 32'd0);
        chk("reset_divz", {31'd0, divz}, 32'd0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run(v[i].a, v[i].b, 1'b0, rr, dz, lat, bok);
            chk($sformatf("vec%0d_r", i), {16'd0, rr}, {16'd0, v[i].r});
            chk($sformatf("vec%0d_divz", i), {31'd0, dz}, {31'd0, v[i].dz});
            chk($sformatf("vec%0d_lat", i), lat, v[i].lat);
            chk($sformatf("vec%0d_busy", i), {31'd0, bok}, 32'd1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // start during DIV with new operands must be ignored
        @(negedge clk);
        a = 16'h40C0; b = 16'h4000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'h3F80; b = 16'h4040; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int i = 3; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; rr = r; break; end
        end
        chk("ignore_lat", lat, LAT);
        chk("ignore_r", {16'd0, rr}, 32'h4040);
        repeat (3) @(posedge clk);
        #1;
        chk("ignore_no_requeue", {31'd0, busy}, 32'd0);

        // back-to-back: second start raised in the done cycle
        run(16'h40C0, 16'h4000, 1'b0, rr, dz, lat, bok);
        chk("b2b_first_r", {16'd0, rr}, 32'h4040);
        run(16'hC0C0, 16'h4000, 1'b1, rr, dz, lat, bok);
        chk("b2b_second_lat", lat, LAT);
        chk("b2b_second_r", {16'd0, rr}, 32'hC040);

        // asynchronous reset mid-divide
        @(negedge clk);
        a = 16'h40C0; b = 16'h4000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_r", {16'd0, r}, 32'd0);
        @(negedge clk) reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("midrst_no_done", {31'd0, seen}, 32'd0);
        run(16'h3F80, 16'h4040, 1'b0, rr, dz, lat, bok);
        chk("postrst_r", {16'd0, rr}, {16'd0, THIRD});
        chk("postrst_lat", lat, LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
